// File: rtl/serial_mag_comp_ctrl.sv
// MSB-first serial magnitude comparator controller.
// Drives one bit pair per cycle into a shared 1-bit comparator.
module serial_mag_comp_ctrl #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             bit_a,
  output logic             bit_b,
  input  logic             cmp_lt,
  input  logic             cmp_eq,
  input  logic             cmp_gt,
  output logic             busy,
  output logic             done,
  output logic             LT,
  output logic             EQ,
  output logic             GT,
  output logic             err,
  output logic [CW-1:0]    nbits
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  generate
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
      $error("serial_mag_comp_ctrl: WIDTH must be 2..32");
    end
  endgenerate

  logic [1:0]       state;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;

  // Outside SCAN the comparator sees bit 0 so its inputs stay quiet.
  assign bit_a = (state == SCAN) ? a_reg[idx] : a_reg[0];
  assign bit_b = (state == SCAN) ? b_reg[idx] : b_reg[0];
  assign busy  = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      a_reg <= '0;
      b_reg <= '0;
      done  <= 1'b0;
      LT    <= 1'b0;
      EQ    <= 1'b0;
      GT    <= 1'b0;
      err   <= 1'b0;
      nbits <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= a_in;
            b_reg <= b_in;
            idx   <= IW'(WIDTH - 1);
            nbits <= '0;
            LT    <= 1'b0;
            EQ    <= 1'b0;
            GT    <= 1'b0;
            err   <= 1'b0;
            state <= SCAN;
          end
        end
        SCAN: begin
          nbits <= nbits + CW'(1);
          case ({cmp_lt, cmp_eq, cmp_gt})
            3'b100: begin
              LT    <= 1'b1;
              done  <= 1'b1;
              state <= DONE;
            end
            3'b001: begin
              GT    <= 1'b1;
              done  <= 1'b1;
              state <= DONE;
            end
            3'b010: begin
              if (idx == '0) begin
                EQ    <= 1'b1;
                done  <= 1'b1;
                state <= DONE;
              end else begin
                idx <= idx - IW'(1);
              end
            end
            default: begin
              err   <= 1'b1;
              done  <= 1'b1;
              state <= DONE;
            end
          endcase
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_mag_comp_ctrl.sv
// Scoreboard bench for serial_mag_comp_ctrl with a behavioural
// 1-bit comparator that can be overridden by a bench driver.
module tb_serial_mag_comp_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a_in = '0;
  logic [7:0] b_in = '0;
  logic       bit_a, bit_b;
  logic       cmp_lt, cmp_eq, cmp_gt;
  logic       busy, done, LT, EQ, GT, err;
  logic [3:0] nbits;

  logic       ovr = 1'b0;
  logic       f_lt = 1'b0, f_eq = 1'b0, f_gt = 1'b0;

  int checks = 0;
  int errors = 0;

  // expected {LT,EQ,GT,err,nbits}
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  assign cmp_lt = ovr ? f_lt : (~bit_a & bit_b);
  assign cmp_eq = ovr ? f_eq : ~(bit_a ^ bit_b);
  assign cmp_gt = ovr ? f_gt : (bit_a & ~bit_b);

  serial_mag_comp_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a_in(a_in), .b_in(b_in),
    .bit_a(bit_a), .bit_b(bit_b),
    .cmp_lt(cmp_lt), .cmp_eq(cmp_eq), .cmp_gt(cmp_gt),
    .busy(busy), .done(done),
    .LT(LT), .EQ(EQ), .GT(GT), .err(err),
    .nbits(nbits)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse is matched against the scoreboard.
  always @(negedge clk) begin
    if (done) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got %b%b%b%b/%0d expected none",
                 LT, EQ, GT, err, nbits);
      end else begin
        logic [7:0] e;
        e = sb.pop_front();
        if ({LT, EQ, GT, err, nbits} !== e) begin
          errors++;
          $display("FAIL result: got %b expected %b",
                   {LT, EQ, GT, err, nbits}, e);
        end
      end
    end
  end

  // Issue one comparison; k = expected nbits. walk checks bit order;
  // disturb re-pulses start with new operands during SCAN cycle 3.
  task automatic run(input logic [7:0] a, input logic [7:0] b,
                     input logic [3:0] res, input int k,
                     input bit walk, input bit disturb);
    int cyc;
    int idx;
    cyc = 0;
    sb.push_back({res, 4'(k)});
    @(negedge clk);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        start = 1'b0;
        chk("accept_clear", {busy, LT, EQ, GT, err}, 5'b10000);
      end
      if (disturb && cyc == 3) begin
        start = 1'b1;
        a_in  = 8'hFF;
        b_in  = 8'h00;
      end
      if (disturb && cyc == 4) start = 1'b0;
      if (done) break;
      if (walk) begin
        idx = 8 - cyc;
        chk("bit_walk", {bit_a, bit_b}, {a[idx], b[idx]});
      end
      if (cyc > 40) begin
        chk("done_timeout", 32'(cyc), 32'(k + 1));
        break;
      end
    end
    chk("latency", 32'(cyc), 32'(k + 1));
    @(negedge clk);
    chk("busy_after_done", {busy, done}, 2'b00);
    chk("held", {LT, EQ, GT, err}, res);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_state",
        {busy, done, LT, EQ, GT, err, nbits, bit_a, bit_b}, 12'h000);
    rst_n = 1'b1;

    // 1: differ at MSB
    run(8'hA5, 8'h25, 4'b0010, 1, 1'b0, 1'b0);
    // 2: differ at LSB, full walk
    run(8'h3C, 8'h3D, 4'b1000, 8, 1'b1, 1'b0);
    // 3: equal, then LT at MSB clears EQ
    run(8'h5A, 8'h5A, 4'b0100, 8, 1'b1, 1'b0);
    run(8'h00, 8'h80, 4'b1000, 1, 1'b0, 1'b0);
    // 4: start and operand changes during SCAN ignored
    run(8'h3C, 8'h3D, 4'b1000, 8, 1'b1, 1'b1);

    // 5: async reset mid-scan
    @(negedge clk);
    a_in  = 8'h3C;
    b_in  = 8'h3D;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset",
        {busy, done, LT, EQ, GT, err, nbits, bit_a, bit_b}, 12'h000);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("no_done_after_reset", 32'(sb.size()), 32'd0);
    run(8'h10, 8'h01, 4'b0010, 4, 1'b1, 1'b0);

    // 6: non-one-hot comparator responses
    ovr  = 1'b1;
    f_lt = 1'b1;
    f_eq = 1'b0;
    f_gt = 1'b1;
    run(8'h12, 8'h34, 4'b0001, 1, 1'b0, 1'b0);
    f_lt = 1'b0;
    f_gt = 1'b0;
    run(8'h12, 8'h34, 4'b0001, 1, 1'b0, 1'b0);
    // forced EQ through all bits, then ordinary run restores
    f_eq = 1'b1;
    run(8'h12, 8'h34, 4'b0100, 8, 1'b0, 1'b0);
    ovr = 1'b0;
    run(8'hFE, 8'hFF, 4'b1000, 8, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
